assist_mode_ctrl: RTL

ASSIST_MODE_CTRL -- requirements
Module: assist_mode_ctrl

---
 rtl/assist_mode_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/assist_mode_ctrl.sv
// Assist mode controller: debounces the mode push-button, classifies short and
// long presses, cycles the assist setting / toggles enable, and soft-ramps the
// motor gain toward the target implied by the current mode.
//
// Handshake note: this block has no valid/ready interfaces; the press events
// are single-cycle internal strobes consumed on the same clock edge that
// retires them from the press FSM.
module assist_mode_ctrl #(
  parameter int DB_CNT   = 16,
  parameter int LONG_CNT = 64,
  parameter int RAMP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tgglMd,
  output logic [1:0] setting,
  output logic       enabled,
  output logic [7:0] gain,
  output logic       ramping,
  output logic [1:0] press_state_o
);

  localparam int DB_W   = $clog2(DB_CNT + 1);
  localparam int HOLD_W = $clog2(LONG_CNT + 1);
  localparam int PRE_W  = $clog2(RAMP_DIV + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CNT - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CNT - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } press_state_t;

  logic              sync1_q, sync2_q;
  logic              btn_db_q, btn_db_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  press_state_t      state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              short_evt, long_evt;
  logic [1:0]        setting_q, setting_d;
  logic              enabled_q, enabled_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [7:0]        gain_q, gain_d;
  logic [7:0]        target;

  // Two-flop synchronizer for the asynchronous push-button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= tgglMd;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: flip the level on the DB_CNT-th consecutive disagreeing cycle.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (sync2_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      btn_db_q <= btn_db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Press FSM next-state; IDLE only ever sees btn_db high on a rising edge
  // because every path back to IDLE requires btn_db low.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    short_evt  = 1'b0;
    long_evt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_db_q) begin
          state_d    = PRESSED;
          hold_cnt_d = '0;
        end
      end
      PRESSED: begin
        if (!btn_db_q) begin
          short_evt = 1'b1;
          state_d   = IDLE;
        end else if (hold_cnt_q == LONG_LAST) begin
          long_evt = 1'b1;
          state_d  = LONG_HELD;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      LONG_HELD: begin
        // Hold counter stays saturated at LONG_LAST; release emits nothing.
        if (!btn_db_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Press FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Mode update: short press cycles 1->2->3->1 when enabled, long press toggles enable.
  always_comb begin
    setting_d = setting_q;
    enabled_d = enabled_q;
    if (short_evt && enabled_q) begin
      setting_d = (setting_q == 2'd3) ? 2'd1 : setting_q + 2'd1;
    end
    if (long_evt) begin
      enabled_d = ~enabled_q;
    end
  end

  // Target gain decoded from mode.
  always_comb begin
    target = 8'h00;
    if (enabled_q) begin
      case (setting_q)
        2'd1:    target = 8'h40;
        2'd2:    target = 8'h80;
        2'd3:    target = 8'hC0;
        default: target = 8'h00;
      endcase
    end
  end

  // Free-running prescaler; gain steps one LSB toward target at terminal count.
  always_comb begin
    pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    gain_d = gain_q;
    if (pre_q == PRE_LAST) begin
      if (gain_q < target)      gain_d = gain_q + 8'd1;
      else if (gain_q > target) gain_d = gain_q - 8'd1;
    end
  end

  // Mode and ramp registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      setting_q <= 2'b10;
      enabled_q <= 1'b1;
      pre_q     <= '0;
      gain_q    <= 8'h00;
    end else begin
      setting_q <= setting_d;
      enabled_q <= enabled_d;
      pre_q     <= pre_d;
      gain_q    <= gain_d;
    end
  end

  assign setting       = setting_q;
  assign enabled       = enabled_q;
  assign gain          = gain_q;
  assign ramping       = (gain_q != target);
  assign press_state_o = state_q;

endmodule
